sub_64_bit: RTL and testbench

Registered 64-bit signed subtractor for the ALU of the pipelined processor. Computes `out = a - b` in two's complement and flags signed overflow. Both results are captured on the rising clock edge, giving one cycle of latency. The block sits in the ALU alongside the adder and logic units.

---
 rtl/sub_64_bit.sv | 46 ++++
 tb/tb_sub_64_bit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sub_64_bit.sv
// sub_64_bit: registered 64-bit signed subtractor (a - b) with overflow flag, one cycle latency.
// Define SUB_64_BIT_ZERO_FLAG_EN to add a registered zero-result flag.
module sub_64_bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] out,
  output logic        overflow
`ifdef SUB_64_BIT_ZERO_FLAG_EN
  ,
  output logic        zero
`endif
);
  logic [64:0] c;
  logic [63:0] diff_d, diff_q;
  logic        ovf_d, ovf_q;
  // Ripple chain of full-adder cells computing a + ~b + 1
  always_comb begin
    c = 65'd0;
    c[0] = 1'b1;
    diff_d = 64'd0;
    for (int i = 0; i < 64; i++) begin
      diff_d[i] = a[i] ^ ~b[i] ^ c[i];
      c[i+1] = (a[i] & ~b[i]) | (c[i] & (a[i] ^ ~b[i]));
    end
    ovf_d = c[63] ^ c[64];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      diff_q <= 64'd0;
      ovf_q <= 1'b0;
    end else begin
      diff_q <= diff_d;
      ovf_q <= ovf_d;
    end
  assign out = diff_q;
  assign overflow = ovf_q;
`ifdef SUB_64_BIT_ZERO_FLAG_EN
  logic zero_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) zero_q <= 1'b0;
    else zero_q <= ~|diff_d;
  assign zero = zero_q;
`endif
endmodule

// File: tb/tb_sub_64_bit.sv
// tb_sub_64_bit: directed and random scoreboard bench for sub_64_bit.
module tb_sub_64_bit;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a, b, out;
  logic        overflow;
`ifdef SUB_64_BIT_ZERO_FLAG_EN
  logic        zero;
`endif
  typedef struct {
    logic [63:0] o;
    logic        v;
    logic        z;
    string       tag;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sub_64_bit dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .out(out),
    .overflow(overflow)
`ifdef SUB_64_BIT_ZERO_FLAG_EN
    ,
    .zero(zero)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_state(input string tag);
    chk({tag, "_out"}, out, 64'd0);
    chk({tag, "_ovf"}, {63'd0, overflow}, 64'd0);
`ifdef SUB_64_BIT_ZERO_FLAG_EN
    chk({tag, "_zero"}, {63'd0, zero}, 64'd0);
`endif
  endtask

  task automatic push(input string tag, input logic [63:0] o, input logic v);
    exp_t e;
    e.o = o;
    e.v = v;
    e.z = (o == 64'd0);
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic collect();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_out"}, out, e.o);
      chk({e.tag, "_ovf"}, {63'd0, overflow}, {63'd0, e.v});
`ifdef SUB_64_BIT_ZERO_FLAG_EN
      chk({e.tag, "_zero"}, {63'd0, zero}, {63'd0, e.z});
`endif
    end
  endtask

  task automatic step(input string tag, input logic [63:0] x, input logic [63:0] y,
                      input logic [63:0] eo, input logic ev);
    @(negedge clk);
    a = x;
    b = y;
    push(tag, eo, ev);
    collect();
  endtask

  task automatic step_model(input string tag, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] d;
    d = x - y;
    step(tag, x, y, d, (x[63] != y[63]) && (d[63] != x[63]));
  endtask

  initial begin
    rst = 1'b1;
    a = 64'd5;
    b = 64'd2;
    #1;
    chk_zero_state("reset_async");
    @(posedge clk);
    #1;
    chk_zero_state("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    push("reset_release", 64'd3, 1'b0);
    collect();

    step("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 64'h8000_0000_0000_0002, 1'b1);
    step("neg_result", 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    step("simple_pos", 64'd7, 64'd4, 64'd3, 1'b0);
    step("neg_ovf", 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    step("zero_sub_min", 64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
    step("minus1_sub_min", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    step("equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0);
    step("after_equal", 64'd1, 64'd0, 64'd1, 1'b0);
    step("borrow_chain", 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    for (int i = 0; i < 12; i++)
      step_model("random", {$urandom, $urandom}, {$urandom, $urandom});

    step("pre_midreset", 64'd7, 64'd4, 64'd3, 1'b0);
    @(negedge clk);
    a = 64'd1;
    b = 64'd2;
    #1;
    rst = 1'b1;
    #1;
    chk_zero_state("midreset_async");
    @(posedge clk);
    #1;
    chk_zero_state("midreset_hold");
    @(negedge clk);
    rst = 1'b0;
    a = 64'd10;
    b = 64'd15;
    push("midreset_release", 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
    collect();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
